// File: rtl/ticket_dispenser.sv
// ticket_dispenser
//   Customer-side kiosk. A rising edge on one of four service buttons prints the
//   next sequential ticket number, tagged with its service type, and queues it in
//   an internal FIFO. Officer-side logic drains the FIFO over a valid/ready port.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   service_button   [3:0] level inputs, bit i = service i
//   issue_valid      one-cycle strobe: a ticket was printed
//   issue_ticket     number of the last printed ticket (held between strobes)
//   issue_service    service of the last printed ticket (held between strobes)
//   reject           one-cycle strobe: press refused because the queue was full
//   busy             printer lockout active
//   full             FIFO holds DEPTH entries
//   q_valid/q_ready  dequeue handshake, pop on q_valid && q_ready
//   q_ticket         head ticket number
//   q_service        head service type
//   waiting_count    number of entries in the FIFO
`timescale 1ns/1ps

module ticket_dispenser #(
  parameter int DEPTH        = 8,
  parameter int TICKET_W     = 7,
  parameter int MAX_TICKET   = 99,
  parameter int PRINT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               service_button,
  output logic                     issue_valid,
  output logic [TICKET_W-1:0]      issue_ticket,
  output logic [1:0]               issue_service,
  output logic                     reject,
  output logic                     busy,
  output logic                     full,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic [TICKET_W-1:0]      q_ticket,
  output logic [1:0]               q_service,
  output logic [$clog2(DEPTH):0]   waiting_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(PRINT_CYCLES + 1);

  typedef enum logic {
    S_IDLE,
    S_PRINT
  } state_t;

  typedef struct packed {
    logic [TICKET_W-1:0] ticket;
    logic [1:0]          service;
  } entry_t;

  // Registers
  state_t              r_state;
  logic [3:0]          r_prev_btn;
  logic [TICKET_W-1:0] r_counter;
  logic [TMR_W-1:0]    r_timer;
  logic                r_busy;
  logic                r_issue_valid;
  logic [TICKET_W-1:0] r_issue_ticket;
  logic [1:0]          r_issue_service;
  logic                r_reject;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  entry_t              r_mem [DEPTH];

  // Combinational signals
  logic [3:0]          w_press;
  logic                w_any_press;
  logic [1:0]          w_svc;
  logic                w_full;
  logic                w_q_valid;
  logic                w_write;
  logic                w_pop;
  entry_t              w_wr_entry;
  entry_t              w_head;

  // Rising-edge detect; the previous-button register resets to all ones so a
  // button held through reset must be released and pressed again.
  assign w_press     = service_button & ~r_prev_btn;
  assign w_any_press = |w_press;

  // Lowest index wins when several buttons rise together.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_svc = 2'd0;
    if      (w_press[0]) w_svc = 2'd0;
    else if (w_press[1]) w_svc = 2'd1;
    else if (w_press[2]) w_svc = 2'd2;
    else if (w_press[3]) w_svc = 2'd3;
  end

  // full and q_valid come from the count registered at the start of the
  // cycle, so a dequeue on the same edge cannot rescue a press into a full FIFO.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_q_valid = (r_count != '0);

  assign w_write    = (r_state == S_IDLE) && w_any_press && !w_full;
  assign w_pop      = w_q_valid && q_ready;
  assign w_wr_entry = '{ticket: r_counter, service: w_svc};
  assign w_head     = r_mem[r_rd_ptr];

  // FIFO storage
  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Control FSM, ticket counter, FIFO pointers and registered outputs
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state         <= S_IDLE;
      r_prev_btn      <= 4'b1111;
      r_counter       <= TICKET_W'(1);
      r_timer         <= '0;
      r_busy          <= 1'b0;
      r_issue_valid   <= 1'b0;
      r_issue_ticket  <= '0;
      r_issue_service <= 2'd0;
      r_reject        <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
    end else begin
      r_prev_btn    <= service_button;
      r_issue_valid <= 1'b0;
      r_reject      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_press) begin
            if (w_full) begin
              r_reject <= 1'b1;
            end else begin
              r_issue_valid   <= 1'b1;
              r_issue_ticket  <= r_counter;
              r_issue_service <= w_svc;
              r_counter       <= (r_counter == TICKET_W'(MAX_TICKET))
                                 ? TICKET_W'(1) : r_counter + TICKET_W'(1);
              r_timer         <= TMR_W'(PRINT_CYCLES);
              r_busy          <= 1'b1;
              r_state         <= S_PRINT;
            end
          end
        end
        S_PRINT: begin
          // Timer was loaded with PRINT_CYCLES on the issuing edge; leaving on
          // the edge where it would hit zero keeps busy high exactly
          // PRINT_CYCLES cycles.
          if (r_timer == TMR_W'(1)) begin
            r_timer <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign issue_valid   = r_issue_valid;
  assign issue_ticket  = r_issue_ticket;
  assign issue_service = r_issue_service;
  assign reject        = r_reject;
  assign busy          = r_busy;
  assign full          = w_full;
  assign q_valid       = w_q_valid;
  assign q_ticket      = w_head.ticket;
  assign q_service     = w_head.service;
  assign waiting_count = r_count;

endmodule

// File: tb/tb_ticket_dispenser.sv
// tb_ticket_dispenser
//   Two instances: u_dut_a with default parameters and u_dut_b with
//   MAX_TICKET=5 for the wrap case. Expected tickets are pushed into queues when
//   a press is issued; monitors on the falling edge pop and compare whenever a
//   DUT strobes issue_valid or completes a q_valid && q_ready handshake.
`timescale 1ns/1ps

module tb_ticket_dispenser;

  localparam int TW = 7;

  typedef struct {
    int ticket;
    int svc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A signals
  logic        reset_a = 1'b1;
  logic [3:0]  btn_a   = 4'b0000;
  logic        q_ready_a = 1'b0;
  logic        issue_valid_a, reject_a, busy_a, full_a, q_valid_a;
  logic [TW-1:0] issue_ticket_a, q_ticket_a;
  logic [1:0]  issue_service_a, q_service_a;
  logic [3:0]  waiting_a;

  // DUT B signals
  logic        reset_b = 1'b1;
  logic [3:0]  btn_b   = 4'b0000;
  logic        q_ready_b = 1'b0;
  logic        issue_valid_b, reject_b, busy_b, full_b, q_valid_b;
  logic [TW-1:0] issue_ticket_b, q_ticket_b;
  logic [1:0]  issue_service_b, q_service_b;
  logic [3:0]  waiting_b;

  ticket_dispenser u_dut_a (
    .clk           (clk),
    .reset         (reset_a),
    .service_button(btn_a),
    .issue_valid   (issue_valid_a),
    .issue_ticket  (issue_ticket_a),
    .issue_service (issue_service_a),
    .reject        (reject_a),
    .busy          (busy_a),
    .full          (full_a),
    .q_valid       (q_valid_a),
    .q_ready       (q_ready_a),
    .q_ticket      (q_ticket_a),
    .q_service     (q_service_a),
    .waiting_count (waiting_a)
  );

  ticket_dispenser #(.MAX_TICKET(5)) u_dut_b (
    .clk           (clk),
    .reset         (reset_b),
    .service_button(btn_b),
    .issue_valid   (issue_valid_b),
    .issue_ticket  (issue_ticket_b),
    .issue_service (issue_service_b),
    .reject        (reject_b),
    .busy          (busy_b),
    .full          (full_b),
    .q_valid       (q_valid_b),
    .q_ready       (q_ready_b),
    .q_ticket      (q_ticket_b),
    .q_service     (q_service_b),
    .waiting_count (waiting_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_issue_a[$];
  exp_t exp_pop_a[$];
  exp_t exp_issue_b[$];
  exp_t exp_pop_b[$];

  int issues_a  = 0;
  int rejects_a = 0;
  int issues_b  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_unexpected(input string name, input int act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got ticket %0d with nothing expected (t=%0t)", name, act, $time);
  endtask

  // Monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (issue_valid_a) begin
      issues_a++;
      if (exp_issue_a.size() == 0) fail_unexpected("issue_a", int'(issue_ticket_a));
      else begin
        e = exp_issue_a.pop_front();
        check("issue_ticket_a", int'(issue_ticket_a), e.ticket);
        check("issue_service_a", int'(issue_service_a), e.svc);
      end
    end
    if (reject_a) rejects_a++;
    if (q_valid_a && q_ready_a) begin
      if (exp_pop_a.size() == 0) fail_unexpected("pop_a", int'(q_ticket_a));
      else begin
        e = exp_pop_a.pop_front();
        check("q_ticket_a", int'(q_ticket_a), e.ticket);
        check("q_service_a", int'(q_service_a), e.svc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (issue_valid_b) begin
      issues_b++;
      if (exp_issue_b.size() == 0) fail_unexpected("issue_b", int'(issue_ticket_b));
      else begin
        e = exp_issue_b.pop_front();
        check("issue_ticket_b", int'(issue_ticket_b), e.ticket);
        check("issue_service_b", int'(issue_service_b), e.svc);
      end
    end
    if (q_valid_b && q_ready_b) begin
      if (exp_pop_b.size() == 0) fail_unexpected("pop_b", int'(q_ticket_b));
      else begin
        e = exp_pop_b.pop_front();
        check("q_ticket_b", int'(q_ticket_b), e.ticket);
        check("q_service_b", int'(q_service_b), e.svc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_issue_a(input int t, input int s);
    exp_t e;
    e.ticket = t; e.svc = s;
    exp_issue_a.push_back(e);
  endtask

  task automatic push_pop_a(input int t, input int s);
    exp_t e;
    e.ticket = t; e.svc = s;
    exp_pop_a.push_back(e);
  endtask

  task automatic push_issue_b(input int t, input int s);
    exp_t e;
    e.ticket = t; e.svc = s;
    exp_issue_b.push_back(e);
  endtask

  task automatic push_pop_b(input int t, input int s);
    exp_t e;
    e.ticket = t; e.svc = s;
    exp_pop_b.push_back(e);
  endtask

  // One press spanning 6 cycles: pressed edge + 4 busy + 1 idle margin.
  task automatic press_a(input logic [3:0] bits, input int t, input int s);
    push_issue_a(t, s);
    btn_a = bits;
    tick(1);
    btn_a = 4'b0000;
    tick(5);
  endtask

  task automatic press_b(input logic [3:0] bits, input int t, input int s, input bit pop);
    push_issue_b(t, s);
    if (pop) push_pop_b(t, s);
    btn_b = bits;
    tick(1);
    btn_b = 4'b0000;
    tick(5);
  endtask

  task automatic reset_dut_a();
    reset_a = 1'b1;
    btn_a = 4'b0000;
    q_ready_a = 1'b0;
    tick(2);
    reset_a = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int busy_cnt;
    bit seen_bad;

    // ---- Test 1: reset, button held through reset, then idle -------------
    reset_a = 1'b1;
    btn_a = 4'b0001;
    tick(3);
    check("rst_q_valid", int'(q_valid_a), 0);
    check("rst_waiting", int'(waiting_a), 0);
    check("rst_issue_ticket", int'(issue_ticket_a), 0);
    reset_a = 1'b0;
    tick(3);
    check("held_through_reset_no_issue", issues_a, 0);
    btn_a = 4'b0000;
    seen_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (q_valid_a || busy_a || full_a || waiting_a != 0) seen_bad = 1'b1;
    end
    check("idle_status_clean", int'(seen_bad), 0);
    check("idle_no_issue", issues_a, 0);
    check("idle_no_reject", rejects_a, 0);

    // ---- Test 2: held button gives one ticket, busy 4 cycles -------------
    push_issue_a(1, 2);
    btn_a = 4'b0100;
    tick(1);
    check("t2_q_valid", int'(q_valid_a), 1);
    check("t2_q_ticket", int'(q_ticket_a), 1);
    check("t2_q_service", int'(q_service_a), 2);
    check("t2_waiting", int'(waiting_a), 1);
    busy_cnt = int'(busy_a);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      busy_cnt += int'(busy_a);
    end
    check("t2_busy_cycles", busy_cnt, 4);
    check("t2_issue_count", issues_a, 1);
    btn_a = 4'b0000;
    tick(3);
    check("t2_issue_ticket_hold", int'(issue_ticket_a), 1);
    check("t2_issue_service_hold", int'(issue_service_a), 2);

    // ---- Test 3: simultaneous rise, press during busy ignored ------------
    reset_dut_a();
    base = issues_a;
    push_issue_a(1, 0);
    btn_a = 4'b0011;
    tick(1);
    check("t3_waiting", int'(waiting_a), 1);
    check("t3_busy", int'(busy_a), 1);
    btn_a = 4'b0000;
    tick(1);
    btn_a = 4'b1000;
    tick(1);
    check("t3_no_reject_in_print", int'(reject_a), 0);
    tick(6);
    check("t3_waiting_after", int'(waiting_a), 1);
    check("t3_issue_count", issues_a - base, 1);
    btn_a = 4'b0000;

    // ---- Test 4: fill, reject, pop, refill, no same-cycle rescue ---------
    reset_dut_a();
    base = issues_a;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] b;
      b = 4'b0001 << (i % 4);
      press_a(b, i + 1, i % 4);
    end
    check("t4_full", int'(full_a), 1);
    check("t4_waiting", int'(waiting_a), 8);
    btn_a = 4'b0010;
    tick(1);
    check("t4_reject", int'(reject_a), 1);
    check("t4_reject_not_busy", int'(busy_a), 0);
    tick(1);
    check("t4_reject_one_cycle", int'(reject_a), 0);
    btn_a = 4'b0000;
    tick(1);
    push_pop_a(1, 0);
    q_ready_a = 1'b1;
    tick(1);
    q_ready_a = 1'b0;
    check("t4_waiting_after_pop", int'(waiting_a), 7);
    check("t4_not_full", int'(full_a), 0);
    press_a(4'b1000, 9, 3);
    check("t4_full_again", int'(full_a), 1);
    check("t4_waiting_again", int'(waiting_a), 8);
    push_pop_a(2, 1);
    btn_a = 4'b0100;
    q_ready_a = 1'b1;
    tick(1);
    q_ready_a = 1'b0;
    btn_a = 4'b0000;
    check("t4_no_rescue_reject", int'(reject_a), 1);
    check("t4_no_rescue_waiting", int'(waiting_a), 7);
    tick(1);
    check("t4_issue_count", issues_a - base, 9);
    check("t4_reject_count", rejects_a, 2);

    // ---- Test 5: write and pop on the same edge --------------------------
    reset_dut_a();
    base = issues_a;
    press_a(4'b0001, 1, 0);
    press_a(4'b0010, 2, 1);
    press_a(4'b0100, 3, 2);
    push_issue_a(4, 3);
    push_pop_a(1, 0);
    btn_a = 4'b1000;
    q_ready_a = 1'b1;
    tick(1);
    check("t5_waiting_same_edge", int'(waiting_a), 3);
    push_pop_a(2, 1);
    push_pop_a(3, 2);
    push_pop_a(4, 3);
    btn_a = 4'b0000;
    tick(3);
    q_ready_a = 1'b0;
    check("t5_waiting_drained", int'(waiting_a), 0);
    check("t5_q_valid_drained", int'(q_valid_a), 0);
    check("t5_pop_queue_empty", exp_pop_a.size(), 0);
    check("t5_issue_count", issues_a - base, 4);

    // ---- Test 6: MAX_TICKET=5 wrap, reset during PRINT -------------------
    reset_b = 1'b0;
    tick(1);
    q_ready_b = 1'b1;
    press_b(4'b0010, 1, 1, 1'b1);
    press_b(4'b0010, 2, 1, 1'b1);
    press_b(4'b0010, 3, 1, 1'b1);
    press_b(4'b0010, 4, 1, 1'b1);
    press_b(4'b0010, 5, 1, 1'b1);
    press_b(4'b0010, 1, 1, 1'b1);
    q_ready_b = 1'b0;
    check("t6_wrap_issue_count", issues_b, 6);
    check("t6_wrap_waiting", int'(waiting_b), 0);
    press_b(4'b0010, 2, 1, 1'b0);
    push_issue_b(3, 1);
    btn_b = 4'b0010;
    tick(1);
    check("t6_busy_before_reset", int'(busy_b), 1);
    check("t6_waiting_before_reset", int'(waiting_b), 2);
    reset_b = 1'b1;
    btn_b = 4'b0000;
    tick(1);
    check("t6_rst_busy", int'(busy_b), 0);
    check("t6_rst_waiting", int'(waiting_b), 0);
    check("t6_rst_q_valid", int'(q_valid_b), 0);
    reset_b = 1'b0;
    tick(1);
    press_b(4'b0001, 1, 0, 1'b0);
    check("t6_after_reset_waiting", int'(waiting_b), 1);
    check("t6_after_reset_q_ticket", int'(q_ticket_b), 1);
    check("t6_issue_count", issues_b, 9);

    check("exp_issue_a_empty", exp_issue_a.size(), 0);
    check("exp_issue_b_empty", exp_issue_b.size(), 0);
    check("exp_pop_b_empty", exp_pop_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
